clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
- Parametrised core-local interruptor, successor to the single-hart read-only mtime block.
- Provides a 64-bit mtime with a configurable prescaler, per-hart mtimecmp and msip registers, and a full read/write AXI-lite-style slave.
- Drives per-hart machine timer (mtip) and software (msip) interrupt lines to the core(s).
- Sits on the system bus behind the crossbar at the CLINT window; only address bits [15:0] are decoded.

Parameters:
- NHART, 1, number of harts; 1..8.
- DIV, 1, mtime increments once every DIV clock cycles; DIV>=1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- arvalid_i  in  1  read address valid
- arready_o  out  1  read address ready
- araddr_i  in  32  read address
- rvalid_o  out  1  read data valid
- rready_i  in  1  read data ready
- rdata_o  out  32  read data
- rresp_o  out  2  read response; 00 OKAY, 10 SLVERR
- awvalid_i  in  1  write address valid
- awready_o  out  1  write address ready
- awaddr_i  in  32  write address
- wvalid_i  in  1  write data valid
- wready_o  out  1  write data ready
- wdata_i  in  32  write data
- wstrb_i  in  4  write byte enables
- bvalid_o  out  1  write response valid
- bready_i  in  1  write response ready
- bresp_o  out  2  write response; 00 OKAY, 10 SLVERR
- msip_o  out  NHART  software interrupt per hart
- mtip_o  out  NHART  timer interrupt per hart

Behaviour:
- Reset is asynchronous and active-high; all state is reset immediately on assertion.
- Reset values:
  - mtime=0, prescaler=0.
  - mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF, msip[h]=0.
  - rvalid_o=0, bvalid_o=0, rdata_o=0, rresp_o=0, bresp_o=0, mtip_o=0, msip_o=0.
- Address map (offset = addr[15:0]):
  - msip[h] at 0x0000+4h; only bit 0 is implemented, other bits read 0.
  - mtimecmp[h] low at 0x4000+8h, high at 0x4004+8h.
  - mtime low at 0xBFF8, high at 0xBFFC.
  - Any other offset, or h>=NHART: reads return 0 with SLVERR; writes are ignored with SLVERR.
- Prescaler:
  - Counts 0..DIV-1; a tick occurs in the cycle where count==DIV-1.
  - On a tick, mtime is incremented by 1 as a full 64-bit add, wrapping from all-ones to 0.
- Read channel:
  - arready_o = !rvalid_o; one read outstanding at a time.
  - On AR handshake, register data and response; rvalid_o=1 on the next cycle.
  - rdata_o and rresp_o are held stable until the R handshake; rvalid_o drops the cycle after rready_i&rvalid_o.
  - Back-to-back reads: at most one read every 2 cycles.
- Write channel:
  - awready_o = wready_o = awvalid_i & wvalid_i & !bvalid_o; AW and W are accepted only together.
  - The register updates at the handshake edge, applying wstrb_i per byte.
  - bvalid_o=1 on the next cycle and is held until bready_i.
- mtime write conflicts:
  - A write to one mtime word overrides the tick for that word in the same cycle.
  - Write to the low word: high word is unchanged, carry suppressed.
  - Write to the high word: low word still increments, carry is dropped.
  - Any mtime write also clears the prescaler to 0.
- A read and a write to the same register in the same cycle: the read returns the pre-write value.
- Interrupts:
  - mtip_o[h] is registered from (mtime >= mtimecmp[h]) using the current register values; it lags the register state by one cycle.
  - mtip_o is level-sensitive; it clears one cycle after mtimecmp is raised above mtime.
  - msip_o[h] = msip[h] bit 0, taken directly from the register.

Optional Feature:
- Macro: CLINT_MTIME_SNAPSHOT_EN.
- Defined:
  - A read of mtime low also latches mtime[63:32] into a shadow register.
  - A read of mtime high returns the shadow, giving a coherent 64-bit read across two 32-bit accesses.
  - Shadow resets to 0; mtime writes do not update it.
- Undefined: no shadow register; a read of mtime high returns the live value.

Test Plan:
- Reset, DIV=1, idle 10 cycles, then read 0xBFF8 -> rdata_o equals the cycle count since reset release ±1, rresp_o=00; read 0xBFFC -> 0.
- Write 0xBFF8=0xFFFF_FFFE, 0xBFFC=0 -> within 3 cycles, high reads 1 and low wraps to a small value (carry into the high word).
- NHART=2: write mtimecmp[1]={0, 0x40} -> mtip_o=2'b10 exactly one cycle after mtime reaches 0x40; mtip_o[0] stays 0; writing mtimecmp[1] high=1 clears mtip_o[1] next cycle.
- Write 0x0004=0xFFFF_FFFF, then read it -> msip_o=2'b10, rdata_o=1; write wstrb=0000 -> no change.
- Read 0x1000 and write 0x8000 -> rresp_o=10, rdata_o=0, bresp_o=10, all state unchanged; hold rready_i=0 for 5 cycles -> rvalid_o and rdata_o remain stable.
- DIV=4 with CLINT_MTIME_SNAPSHOT_EN defined: mtime advances 1 per 4 cycles; set mtime low to 0xFFFF_FFFF, read low, wait for the carry, read high -> returns the pre-carry high value.

Source files
------------

// File: rtl/clint_timer.sv
`timescale 1ns/1ps
// clint_timer: core-local interruptor with prescaled 64-bit mtime, per-hart mtimecmp/msip and an AXI-lite slave.
// Define CLINT_MTIME_SNAPSHOT_EN so that a read of mtime low latches the high word for coherent 64-bit reads.
module clint_timer #(
    parameter int NHART = 1,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arvalid_i,
    output logic             arready_o,
    input  logic [31:0]      araddr_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [31:0]      rdata_o,
    output logic [1:0]       rresp_o,
    input  logic             awvalid_i,
    output logic             awready_o,
    input  logic [31:0]      awaddr_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    output logic             bvalid_o,
    input  logic             bready_i,
    output logic [1:0]       bresp_o,
    output logic [NHART-1:0] msip_o,
    output logic [NHART-1:0] mtip_o
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int HW = NHART > 1 ? $clog2(NHART) : 1;

    typedef enum logic [1:0] {K_ERR, K_MSIP, K_CMP, K_TIME} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [2:0] h;
        logic       hi;
    } dec_t;

    // Only offset bits [15:0] are decoded; unaligned or out-of-range harts fall through to K_ERR.
    function automatic dec_t decode(input logic [31:0] addr);
        logic [15:0] off;
        off = addr[15:0];
        decode = '{kind: K_ERR, h: 3'd0, hi: 1'b0};
        if (off[1:0] == 2'b00) begin
            if (off[15:5] == 11'd0 && 32'(off[4:2]) < NHART)
                decode = '{kind: K_MSIP, h: off[4:2], hi: 1'b0};
            else if (off[15:6] == 10'h100 && 32'(off[5:3]) < NHART)
                decode = '{kind: K_CMP, h: off[5:3], hi: off[2]};
            else if (off[15:3] == 13'h17FF)
                decode = '{kind: K_TIME, h: 3'd0, hi: off[2]};
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
        for (int b = 0; b < 4; b++)
            merge[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
    endfunction

    logic [63:0]      mtime, mtime_inc, mtime_nxt;
    logic [PW-1:0]    pre;
    logic [63:0]      mtimecmp [NHART];
    logic [NHART-1:0] msip, mtip;
    logic             tick, wr, rd, wr_lo, wr_hi;
    dec_t             wd, rdc;
    logic [HW-1:0]    rh;
    logic [31:0]      rd_val, mtime_hi_rd;

    assign wd        = decode(awaddr_i);
    assign rdc       = decode(araddr_i);
    assign rh        = rdc.h[HW-1:0];
    assign wr        = awvalid_i & wvalid_i & ~bvalid_o;
    assign awready_o = wr;
    assign wready_o  = wr;
    assign arready_o = ~rvalid_o;
    assign rd        = arvalid_i & ~rvalid_o;
    assign tick      = pre == PW'(DIV - 1);
    assign wr_lo     = wr && wd.kind == K_TIME && !wd.hi;
    assign wr_hi     = wr && wd.kind == K_TIME && wd.hi;
    assign mtime_inc = mtime + 64'd1;
    assign msip_o    = msip;
    assign mtip_o    = mtip;

    // A written word overrides its own tick; a low write also blocks the carry into the high word.
    assign mtime_nxt = {wr_hi ? merge(mtime[63:32], wdata_i, wstrb_i) :
                        (tick && !wr_lo) ? mtime_inc[63:32] : mtime[63:32],
                        wr_lo ? merge(mtime[31:0], wdata_i, wstrb_i) :
                        tick ? mtime_inc[31:0] : mtime[31:0]};

`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [31:0] shadow;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            shadow <= '0;
        else if (rd && rdc.kind == K_TIME && !rdc.hi)
            shadow <= mtime[63:32];
    end
    assign mtime_hi_rd = shadow;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    always_comb begin
        rd_val = rdc.kind == K_MSIP ? {31'd0, msip[rh]} :
                 rdc.kind == K_CMP  ? (rdc.hi ? mtimecmp[rh][63:32] : mtimecmp[rh][31:0]) :
                 rdc.kind == K_TIME ? (rdc.hi ? mtime_hi_rd : mtime[31:0]) : 32'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime    <= '0;
            pre      <= '0;
            msip     <= '0;
            mtip     <= '0;
            for (int h = 0; h < NHART; h++)
                mtimecmp[h] <= '1;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            rresp_o  <= '0;
            bvalid_o <= 1'b0;
            bresp_o  <= '0;
        end else begin
            mtime <= mtime_nxt;
            pre   <= (wr_lo || wr_hi || tick) ? '0 : pre + 1'b1;
            for (int h = 0; h < NHART; h++) begin
                if (wr && wd.kind == K_CMP && wd.h == 3'(h) && !wd.hi)
                    mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], wdata_i, wstrb_i);
                if (wr && wd.kind == K_CMP && wd.h == 3'(h) && wd.hi)
                    mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wdata_i, wstrb_i);
                if (wr && wd.kind == K_MSIP && wd.h == 3'(h) && wstrb_i[0])
                    msip[h] <= wdata_i[0];
                mtip[h] <= mtime >= mtimecmp[h];
            end
            if (rd) begin
                rvalid_o <= 1'b1;
                rdata_o  <= rd_val;
                rresp_o  <= rdc.kind == K_ERR ? 2'b10 : 2'b00;
            end else if (rready_i) begin
                rvalid_o <= 1'b0;
            end
            if (wr) begin
                bvalid_o <= 1'b1;
                bresp_o  <= wd.kind == K_ERR ? 2'b10 : 2'b00;
            end else if (bready_i) begin
                bvalid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
`timescale 1ns/1ps
// tb_clint_timer: runs a 2-hart DIV=1 and a 1-hart DIV=4 instance on the same bus stimulus,
// each checked against an arithmetic model of mtime, mtimecmp, msip and the optional snapshot.
module tb_clint_timer;
    logic        clock = 1'b0, reset = 1'b1;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        arready [2], rvalid [2], awready [2], wready [2], bvalid [2];
    logic [31:0] rdata [2];
    logic [1:0]  rresp [2], bresp [2];
    logic [1:0]  msip0, mtip0;
    logic [0:0]  msip1, mtip1;

    always #5 clock = ~clock;

    clint_timer #(.NHART(2), .DIV(1)) u0 (
        .clock(clock), .reset(reset),
        .arvalid_i(arvalid), .arready_o(arready[0]), .araddr_i(araddr),
        .rvalid_o(rvalid[0]), .rready_i(rready), .rdata_o(rdata[0]), .rresp_o(rresp[0]),
        .awvalid_i(awvalid), .awready_o(awready[0]), .awaddr_i(awaddr),
        .wvalid_i(wvalid), .wready_o(wready[0]), .wdata_i(wdata), .wstrb_i(wstrb),
        .bvalid_o(bvalid[0]), .bready_i(bready), .bresp_o(bresp[0]),
        .msip_o(msip0), .mtip_o(mtip0));

    clint_timer #(.NHART(1), .DIV(4)) u1 (
        .clock(clock), .reset(reset),
        .arvalid_i(arvalid), .arready_o(arready[1]), .araddr_i(araddr),
        .rvalid_o(rvalid[1]), .rready_i(rready), .rdata_o(rdata[1]), .rresp_o(rresp[1]),
        .awvalid_i(awvalid), .awready_o(awready[1]), .awaddr_i(awaddr),
        .wvalid_i(wvalid), .wready_o(wready[1]), .wdata_i(wdata), .wstrb_i(wstrb),
        .bvalid_o(bvalid[1]), .bready_i(bready), .bresp_o(bresp[1]),
        .msip_o(msip1), .mtip_o(mtip1));

    // Model: mtime after edge e is base + (e - be) / DIV, where be is the edge that last zeroed the prescaler.
    int          nh [2] = '{2, 1};
    int          dv [2] = '{1, 4};
    logic [63:0] base [2];
    longint      be [2];
    logic [63:0] cmp [2][2];
    logic [1:0]  sw [2];
    logic [31:0] snap [2];
    logic [31:0] last_r [2];
    int          n_chk = 0, n_fail = 0;

    function automatic longint cur_e();
        return longint'($time - 5) / 10;
    endfunction

    function automatic logic [63:0] mt(input int i, input longint e);
        return base[i] + 64'((e - be[i]) / dv[i]);
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    function automatic logic [32:0] rd_exp(input int i, input logic [31:0] a, input longint e);
        logic [63:0] t;
        t = mt(i, e - 1);
        if (a[15:0] == 16'hBFF8) return {1'b0, t[31:0]};
`ifdef CLINT_MTIME_SNAPSHOT_EN
        if (a[15:0] == 16'hBFFC) return {1'b0, snap[i]};
`else
        if (a[15:0] == 16'hBFFC) return {1'b0, t[63:32]};
`endif
        for (int h = 0; h < nh[i]; h++) begin
            if (a[15:0] == 16'(4 * h)) return {1'b0, 31'd0, sw[i][h]};
            if (a[15:0] == 16'(16'h4000 + 8 * h)) return {1'b0, cmp[i][h][31:0]};
            if (a[15:0] == 16'(16'h4004 + 8 * h)) return {1'b0, cmp[i][h][63:32]};
        end
        return {1'b1, 32'd0};
    endfunction

    function automatic logic wr_apply(input int i, input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, input longint e);
        logic [63:0] p, q;
        p = mt(i, e - 1);
        q = mt(i, e);
        if (a[15:0] == 16'hBFF8) begin base[i] = {p[63:32], mrg(p[31:0], d, s)}; be[i] = e; return 1'b0; end
        if (a[15:0] == 16'hBFFC) begin base[i] = {mrg(p[63:32], d, s), q[31:0]}; be[i] = e; return 1'b0; end
        for (int h = 0; h < nh[i]; h++) begin
            if (a[15:0] == 16'(4 * h)) begin if (s[0]) sw[i][h] = d[0]; return 1'b0; end
            if (a[15:0] == 16'(16'h4000 + 8 * h)) begin cmp[i][h][31:0] = mrg(cmp[i][h][31:0], d, s); return 1'b0; end
            if (a[15:0] == 16'(16'h4004 + 8 * h)) begin cmp[i][h][63:32] = mrg(cmp[i][h][63:32], d, s); return 1'b0; end
        end
        return 1'b1;
    endfunction

    // One bus transaction: optional read and/or write issued in the same cycle, read data held for 'hold' cycles.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                        input logic [31:0] d, input logic [3:0] s, input int hold);
        logic [32:0] rx [2];
        logic        we [2];
        logic [63:0] t;
        longint      e;
        @(negedge clock);
        arvalid = rd; araddr = ra; awvalid = wr; wvalid = wr; awaddr = wa; wdata = d; wstrb = s;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({arready[i], awready[i], wready[i]} !== {1'b1, wr, wr}) begin
                n_fail++; $display("FAIL ready u%0d: ar/aw/w=%b%b%b expected 1%b%b", i, arready[i], awready[i], wready[i], wr, wr);
            end
        end
        @(posedge clock);
        e = cur_e();
        for (int i = 0; i < 2; i++) begin
            if (rd) begin
                rx[i] = rd_exp(i, ra, e);
                t = mt(i, e - 1);
                if (ra[15:0] == 16'hBFF8) snap[i] = t[63:32];
            end
            if (wr) we[i] = wr_apply(i, wa, d, s, e);
        end
        @(negedge clock);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (rd) begin
                    n_chk++;
                    if ({rvalid[i], rresp[i], rdata[i]} !== {1'b1, rx[i][32], 1'b0, rx[i][31:0]}) begin
                        n_fail++; $display("FAIL read u%0d addr=%h cyc%0d: valid=%b resp=%b data=%h expected 1 %b0 %h",
                                           i, ra, k, rvalid[i], rresp[i], rdata[i], rx[i][32], rx[i][31:0]);
                    end
                    last_r[i] = rdata[i];
                end
                if (wr && k == 0) begin
                    n_chk++;
                    if ({bvalid[i], bresp[i]} !== {1'b1, we[i], 1'b0}) begin
                        n_fail++; $display("FAIL write u%0d addr=%h: bvalid=%b bresp=%b expected 1 %b0", i, wa, bvalid[i], bresp[i], we[i]);
                    end
                end
            end
        end
        rready = 1'b1; bready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rready = 1'b0; bready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({rvalid[i], bvalid[i]} !== 2'b00) begin
                n_fail++; $display("FAIL release u%0d: rvalid=%b bvalid=%b expected 00", i, rvalid[i], bvalid[i]);
            end
        end
    endtask

    task automatic rd_(input logic [31:0] a, input int hold = 0);
        xfer(1'b1, 1'b0, a, 32'd0, 32'd0, 4'd0, hold);
    endtask

    task automatic wr_(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        xfer(1'b0, 1'b1, 32'd0, a, d, s, 0);
    endtask

    task automatic test_reset;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({rvalid[i], bvalid[i], rdata[i], rresp[i], bresp[i]} !== 37'd0) begin
                n_fail++; $display("FAIL reset_bus u%0d: rv=%b bv=%b rdata=%h rresp=%b bresp=%b expected zeros",
                                   i, rvalid[i], bvalid[i], rdata[i], rresp[i], bresp[i]);
            end
        end
        n_chk++;
        if ({msip0, mtip0, msip1, mtip1} !== 6'd0) begin
            n_fail++; $display("FAIL reset_irq: msip0=%b mtip0=%b msip1=%b mtip1=%b expected 0", msip0, mtip0, msip1, mtip1);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            base[i] = '0; be[i] = cur_e(); sw[i] = '0; snap[i] = '0;
            cmp[i][0] = '1; cmp[i][1] = '1;
        end
        repeat (10) @(negedge clock);
        rd_(32'h0000_BFF8);
        rd_(32'h0000_BFFC);
        n_chk++;
        if (last_r[0] !== 32'd0) begin n_fail++; $display("FAIL reset_high: got %h expected 0", last_r[0]); end
    endtask

    task automatic test_wrap;
        wr_(32'h0000_BFFC, 32'd0);
        wr_(32'h0000_BFF8, 32'hFFFF_FFFE);
        rd_(32'h0000_BFF8);
        rd_(32'h0000_BFFC);
        n_chk++;
        if (last_r[0] !== 32'd1) begin n_fail++; $display("FAIL wrap_carry: high=%h expected 1", last_r[0]); end
    endtask

    task automatic test_mtip;
        logic [63:0] t0, t1;
        longint      e;
        bit          seen = 1'b0;
        wr_(32'h0000_BFF8, 32'd0);
        wr_(32'h0000_BFFC, 32'd0);
        wr_(32'h0000_4008, 32'h40);
        wr_(32'h0000_400C, 32'd0);
        repeat (80) begin
            @(negedge clock);
            e = cur_e();
            t0 = mt(0, e - 1);
            t1 = mt(1, e - 1);
            n_chk++;
            if ({mtip0, mtip1} !== {t0 >= cmp[0][1], t0 >= cmp[0][0], t1 >= cmp[1][0]}) begin
                n_fail++; $display("FAIL mtip mtime=%h: mtip0=%b mtip1=%b expected %b%b %b", t0, mtip0, mtip1,
                                   t0 >= cmp[0][1], t0 >= cmp[0][0], t1 >= cmp[1][0]);
            end
            if (mtip0[1]) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL mtip_rise: mtip0[1] never set, expected set"); end
        wr_(32'h0000_400C, 32'd1);
        n_chk++;
        if (mtip0 !== 2'b00) begin n_fail++; $display("FAIL mtip_clear: mtip0=%b expected 00", mtip0); end
    endtask

    task automatic test_msip;
        wr_(32'h0000_0004, 32'hFFFF_FFFF);
        n_chk++;
        if ({msip0, msip1} !== {sw[0], sw[1][0]} || msip0 !== 2'b10) begin
            n_fail++; $display("FAIL msip_set: msip0=%b msip1=%b expected 10 0", msip0, msip1);
        end
        rd_(32'h0000_0004);
        n_chk++;
        if (last_r[0] !== 32'd1) begin n_fail++; $display("FAIL msip_read: got %h expected 1", last_r[0]); end
        wr_(32'h0000_0004, 32'd0, 4'h0);
        n_chk++;
        if (msip0 !== 2'b10) begin n_fail++; $display("FAIL msip_nostrb: msip0=%b expected 10", msip0); end
        wr_(32'hABCD_0000, 32'h1, 4'h1);
        n_chk++;
        if ({msip0, msip1} !== 3'b111) begin n_fail++; $display("FAIL msip_h0: msip0=%b msip1=%b expected 11 1", msip0, msip1); end
    endtask

    task automatic test_error;
        rd_(32'h0000_1000);
        wr_(32'h0000_8000, 32'hDEAD_BEEF);
        n_chk++;
        if ({msip0, msip1} !== {sw[0], sw[1][0]}) begin
            n_fail++; $display("FAIL err_state: msip0=%b msip1=%b expected %b %b", msip0, msip1, sw[0], sw[1][0]);
        end
        rd_(32'h0000_4008);
        rd_(32'h0000_BFF8, 5);
    endtask

    task automatic test_snapshot;
        wr_(32'h0000_BFF8, 32'hFFFF_FFFF);
        rd_(32'h0000_BFF8);
        repeat (12) @(negedge clock);
        rd_(32'h0000_BFFC);
    endtask

    task automatic test_back_to_back;
        logic [15:0] offs [13] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008, 16'h400C,
                                   16'h4010, 16'hBFF8, 16'hBFFC, 16'hBFF4, 16'h1000, 16'h0002};
        logic [31:0] ra, wa;
        int          op;
        repeat (40) begin
            op = $urandom_range(0, 2);
            ra = {16'($urandom), offs[$urandom_range(0, 12)]};
            wa = $urandom_range(0, 1) ? ra : {16'($urandom), offs[$urandom_range(0, 12)]};
            xfer(op != 1, op != 0, ra, wa, $urandom, 4'($urandom), 0);
        end
    endtask

    task automatic test_async_reset;
        wr_(32'h0000_0000, 32'h1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({msip0, msip1, rvalid[0], bvalid[0]} !== 5'd0) begin
            n_fail++; $display("FAIL async_reset: msip0=%b msip1=%b rv=%b bv=%b expected 0", msip0, msip1, rvalid[0], bvalid[0]);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        test_reset;
        test_wrap;
        test_mtip;
        test_msip;
        test_error;
        test_snapshot;
        test_back_to_back;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
